sysmon_adc_scheduler: RTL and testbench
=======================================

// Module: sysmon_adc_scheduler
// PURPOSE
//   Shares the single external ADC, and its input mux, between NUM_REQ system-monitor requesters
//   (AA rail, Li rail, spare channels).
//   Round-robin arbitration over latched request pulses. Per conversion: drives the mux select,
//   waits a settle time, pulses the ADC request, then waits for ready or timeout.
//   Returns the 14-bit result tagged with the requester id. Sits between the battery/LED logic
//   and the ADC front end.
// PARAMETERS
//   NUM_REQ         4     number of requesters; requester i selects mux input i
//   SEL_W           2     width of adc_sel and rsp_id; must satisfy 2**SEL_W >= NUM_REQ
//   SETTLE_CYCLES   1000  cycles adc_sel is held stable before adc_req; must be >= 1
//   TIMEOUT_CYCLES  4096  cycles to wait for adc_ready after adc_req; must be >= 2
//   GAP_CYCLES      16    idle cycles after each completion before the next grant; must be >= 1
// PORTS
//   clk           in   1        system clock (8.388608 MHz)
//   reset         in   1        synchronous, active-high
//   enable        in   1        1 = new grants allowed; a conversion in flight always completes
//   req           in   NUM_REQ  per-requester 1-cycle request pulses
//   pending       out  NUM_REQ  latched, not-yet-granted requests
//   adc_sel       out  SEL_W    external mux select, registered
//   adc_req       out  1        1-cycle conversion start strobe to the ADC
//   adc_ready     in   1        1-cycle result strobe from the ADC
//   adc_value     in   14       ADC result, valid when adc_ready=1
//   rsp_valid     out  1        1-cycle completion strobe
//   rsp_id        out  SEL_W    requester served, valid with rsp_valid
//   rsp_value     out  14       result; 0 when rsp_timeout=1
//   rsp_timeout   out  1        completion was caused by timeout
//   busy          out  1        1 in every state except IDLE
//   timeout_count out  8        saturating count of timeouts
// BEHAVIOUR
//   Reset (sync): state=IDLE, pending=0, adc_sel=0, adc_req=0, rsp_*=0, timeout_count=0,
//     rr_last=NUM_REQ-1, so the first search starts at requester 0. Reset mid-conversion
//     abandons it with no rsp.
//   pending[i] is set by req[i]=1 and cleared on grant of i. Set and clear in the same cycle:
//     set wins, so one more conversion is queued. Repeated pulses while pending merge into one.
//   FSM:
//     IDLE   : if enable && pending!=0, grant the first pending index searching rr_last+1
//              upward with wrap. rr_last<=g, adc_sel<=g, clear pending[g], go SETTLE.
//     SETTLE : count SETTLE_CYCLES cycles (the first counted cycle is the one after the grant),
//              then go START.
//     START  : adc_req=1 for exactly this cycle, then go WAIT. adc_ready in START is ignored.
//     WAIT   : on adc_ready: rsp_value<=adc_value, rsp_timeout<=0, go DONE.
//              If TIMEOUT_CYCLES pass without ready: rsp_value<=0, rsp_timeout<=1,
//              timeout_count<=min(timeout_count+1, 255), go DONE.
//              adc_ready in the final timeout cycle counts as success.
//     DONE   : rsp_valid=1 for exactly this cycle, with rsp_id=rr_last. Then go GAP.
//     GAP    : GAP_CYCLES cycles, then go IDLE.
//   adc_ready outside WAIT is ignored and never produces an rsp.
//   adc_sel holds its value from grant until the next grant; it never changes outside
//     IDLE->SETTLE.
//   Latency for an uncontended request pulse at cycle T, with IDLE and enable=1:
//     pending visible at T+1; grant at T+1; adc_req at T+2+SETTLE_CYCLES;
//     rsp_valid 2 cycles after adc_ready.
//   enable=0: no new grants; pending keeps accumulating; the in-flight conversion finishes
//     normally.
//   rsp_id/rsp_value/rsp_timeout hold their values until the next DONE.
// TESTING (SETTLE_CYCLES=4, TIMEOUT_CYCLES=16, GAP_CYCLES=2, NUM_REQ=4)
//   1 Single: req[1] pulse at cycle 10 -> adc_sel=1 at 12; adc_req at exactly 16 only;
//     adc_ready with value 14'h0700 at 20 -> rsp_valid at 22, rsp_id=1, rsp_value=14'h0700,
//     rsp_timeout=0.
//   2 Fairness: req=4'b1111 in one cycle -> grants in order 0,1,2,3, each with exactly one
//     rsp. Then req[0] and req[3] together -> 0 then 3.
//   3 Timeout: no adc_ready -> rsp_valid 17 cycles after adc_req with rsp_timeout=1,
//     rsp_value=0, timeout_count=1. 300 timeouts -> timeout_count=255.
//   4 Races: req[2] in the same cycle as grant of 2 -> a second conversion for 2.
//     adc_ready in START and in GAP -> ignored, no extra rsp.
//     3 pulses of req[0] while pending -> one conversion.
//   5 Enable/reset: enable=0 during SETTLE -> that conversion completes, then busy=0 while
//     pending stays set. Re-enable -> grant next cycle.
//     reset during WAIT -> all outputs 0 next cycle and no rsp.

Source files
------------

// File: rtl/sysmon_adc_scheduler.sv
// Round-robin scheduler sharing one external ADC and its input mux between NUM_REQ requesters.
// Each conversion: select mux, settle, strobe adc_req, wait for adc_ready or timeout, report.
module sysmon_adc_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int SEL_W          = 2,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] pending,
    output logic [SEL_W-1:0]   adc_sel,
    output logic               adc_req,
    input  logic               adc_ready,
    input  logic [13:0]        adc_value,
    output logic               rsp_valid,
    output logic [SEL_W-1:0]   rsp_id,
    output logic [13:0]        rsp_value,
    output logic               rsp_timeout,
    output logic               busy,
    output logic [7:0]         timeout_count
);

    localparam int MAX_A   = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CNT = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [NUM_REQ-1:0] pending_r, pending_s, clr_mask_s;
    logic [SEL_W-1:0]   rr_last_r, rr_last_s;
    logic [SEL_W-1:0]   adc_sel_r, adc_sel_s;
    logic               adc_req_r, adc_req_s;
    logic               rsp_valid_r, rsp_valid_s;
    logic [SEL_W-1:0]   rsp_id_r, rsp_id_s;
    logic [13:0]        rsp_value_r, rsp_value_s;
    logic               rsp_timeout_r, rsp_timeout_s;
    logic               busy_r, busy_s;
    logic [7:0]         tcount_r, tcount_s;

    logic               grant_found_s;
    logic [SEL_W-1:0]   grant_idx_s;
    logic [SEL_W-1:0]   cand_s;
    logic               hit_s;

    // Round-robin search: walk from the farthest candidate down to rr_last+1 so the nearest hit wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        hit_s         = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s        = SEL_W'((int'(rr_last_r) + k) % NUM_REQ);
            hit_s         = |(pending_r & (NUM_REQ'(1) << cand_s));
            grant_idx_s   = hit_s ? cand_s : grant_idx_s;
            grant_found_s = grant_found_s | hit_s;
        end
    end

    // Next-state and next-output logic for the conversion sequencer.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        rr_last_s     = rr_last_r;
        adc_sel_s     = adc_sel_r;
        adc_req_s     = 1'b0;
        rsp_valid_s   = 1'b0;
        rsp_id_s      = rsp_id_r;
        rsp_value_s   = rsp_value_r;
        rsp_timeout_s = rsp_timeout_r;
        tcount_s      = tcount_r;
        clr_mask_s    = '0;
        case (state_r)
            ST_IDLE: begin
                if (enable && grant_found_s) begin
                    state_s    = ST_SETTLE;
                    rr_last_s  = grant_idx_s;
                    adc_sel_s  = grant_idx_s;
                    clr_mask_s = NUM_REQ'(1) << grant_idx_s;
                    cnt_s      = '0;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_s   = ST_START;
                    adc_req_s = 1'b1;
                    cnt_s     = '0;
                end else begin
                    cnt_s     = cnt_r + CNT_W'(1);
                end
            end
            ST_START: begin
                // The START cycle is the first cycle of the timeout window.
                state_s = ST_WAIT;
                cnt_s   = CNT_W'(1);
            end
            ST_WAIT: begin
                if (adc_ready) begin
                    state_s       = ST_DONE;
                    rsp_value_s   = adc_value;
                    rsp_timeout_s = 1'b0;
                end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_s       = ST_DONE;
                    rsp_value_s   = 14'd0;
                    rsp_timeout_s = 1'b1;
                    tcount_s      = (tcount_r == 8'd255) ? 8'd255 : tcount_r + 8'd1;
                end else begin
                    cnt_s         = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_s     = ST_GAP;
                rsp_valid_s = 1'b1;
                rsp_id_s    = rr_last_r;
                cnt_s       = '0;
            end
            ST_GAP: begin
                if (cnt_r == CNT_W'(GAP_CYCLES - 1)) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
        // A new pulse in the grant cycle re-queues the requester.
        pending_s = (pending_r & ~clr_mask_s) | req;
        busy_s    = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            pending_r     <= '0;
            rr_last_r     <= SEL_W'(NUM_REQ - 1);
            adc_sel_r     <= '0;
            adc_req_r     <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_id_r      <= '0;
            rsp_value_r   <= 14'd0;
            rsp_timeout_r <= 1'b0;
            busy_r        <= 1'b0;
            tcount_r      <= 8'd0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            pending_r     <= pending_s;
            rr_last_r     <= rr_last_s;
            adc_sel_r     <= adc_sel_s;
            adc_req_r     <= adc_req_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_id_r      <= rsp_id_s;
            rsp_value_r   <= rsp_value_s;
            rsp_timeout_r <= rsp_timeout_s;
            busy_r        <= busy_s;
            tcount_r      <= tcount_s;
        end
    end

    assign pending       = pending_r;
    assign adc_sel       = adc_sel_r;
    assign adc_req       = adc_req_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_id        = rsp_id_r;
    assign rsp_value     = rsp_value_r;
    assign rsp_timeout   = rsp_timeout_r;
    assign busy          = busy_r;
    assign timeout_count = tcount_r;

endmodule

// File: tb/tb_sysmon_adc_scheduler.sv
// Directed bench for sysmon_adc_scheduler with short settle/timeout/gap parameters.
module tb_sysmon_adc_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  req;
    logic [3:0]  pending;
    logic [1:0]  adc_sel;
    logic        adc_req;
    logic        adc_ready;
    logic [13:0] adc_value;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [13:0] rsp_value;
    logic        rsp_timeout;
    logic        busy;
    logic [7:0]  timeout_count;

    int checks    = 0;
    int failures  = 0;
    int rsp_seen  = 0;
    int base;

    sysmon_adc_scheduler #(
        .NUM_REQ(4), .SEL_W(2), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(16), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .req(req), .pending(pending),
        .adc_sel(adc_sel), .adc_req(adc_req), .adc_ready(adc_ready), .adc_value(adc_value),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_value(rsp_value),
        .rsp_timeout(rsp_timeout), .busy(busy), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rsp_valid === 1'b1) rsp_seen <= rsp_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_adc_req(input string tag);
        int n = 0;
        while (adc_req !== 1'b1 && n < 80) begin tick(); n++; end
        chk(tag, {31'd0, adc_req}, 32'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 80) begin tick(); n++; end
        chk(tag, {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 80) begin tick(); n++; end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    // One conversion answered one cycle into WAIT; checks the response two cycles later.
    task automatic conv(input logic [1:0] id, input logic [13:0] val, input string tag);
        wait_adc_req(tag);
        chk(tag, adc_sel, id);
        tick();
        adc_ready = 1'b1; adc_value = val;
        tick();
        adc_ready = 1'b0; adc_value = 14'd0;
        tick();
        chk(tag, rsp_valid, 1'b1);
        chk(tag, rsp_id, id);
        chk(tag, rsp_value, val);
        chk(tag, rsp_timeout, 1'b0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; req = 4'd0; adc_ready = 1'b0; adc_value = 14'd0;
        tick(); tick(); tick();
        reset = 1'b0;
        chk("rst_pending", pending, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sel", adc_sel, 2'd0);
        chk("rst_adcreq", adc_req, 1'b0);
        chk("rst_tcount", timeout_count, 8'd0);
        tick(); tick();

        // Single uncontended request: pulse at T.
        req = 4'b0010; tick(); req = 4'b0000;
        chk("t1_pend", pending, 4'b0010);
        chk("t1_busy0", busy, 1'b0);
        tick();
        chk("t1_sel", adc_sel, 2'd1);
        chk("t1_busy1", busy, 1'b1);
        chk("t1_pendclr", pending, 4'b0000);
        for (int k = 2; k <= 9; k++) begin
            chk("t1_adcreq", adc_req, (k == 6));
            chk("t1_norsp", rsp_valid, 1'b0);
            tick();
        end
        adc_ready = 1'b1; adc_value = 14'h0700; tick();
        adc_ready = 1'b0; adc_value = 14'd0;
        chk("t1_rsp_early", rsp_valid, 1'b0);
        tick();
        chk("t1_rsp", rsp_valid, 1'b1);
        chk("t1_id", rsp_id, 2'd1);
        chk("t1_val", rsp_value, 14'h0700);
        chk("t1_to", rsp_timeout, 1'b0);
        tick();
        chk("t1_rsp_once", rsp_valid, 1'b0);
        chk("t1_id_hold", rsp_id, 2'd1);
        chk("t1_gapbusy", busy, 1'b1);
        tick();
        chk("t1_idle", busy, 1'b0);
        chk("t1_sel_hold", adc_sel, 2'd1);

        // Fairness from reset.
        reset = 1'b1; tick(); reset = 1'b0;
        base = rsp_seen;
        req = 4'b1111; tick(); req = 4'b0000;
        conv(2'd0, 14'h0101, "fair0");
        conv(2'd1, 14'h0202, "fair1");
        conv(2'd2, 14'h0303, "fair2");
        conv(2'd3, 14'h0404, "fair3");
        tick(); tick(); tick();
        chk("fair_count", rsp_seen - base, 32'd4);
        req = 4'b1001; tick(); req = 4'b0000;
        conv(2'd0, 14'h1111, "fair03_a");
        conv(2'd3, 14'h1333, "fair03_b");

        // Timeout.
        req = 4'b0100; tick(); req = 4'b0000;
        wait_adc_req("to_req");
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("to_norsp", rsp_valid, 1'b0);
        end
        tick();
        chk("to_rsp", rsp_valid, 1'b1);
        chk("to_flag", rsp_timeout, 1'b1);
        chk("to_val", rsp_value, 14'd0);
        chk("to_id", rsp_id, 2'd2);
        chk("to_count1", timeout_count, 8'd1);

        // Ready in the last timeout cycle counts as success.
        req = 4'b0010; tick(); req = 4'b0000;
        wait_adc_req("lastcyc_req");
        for (int k = 1; k <= 15; k++) tick();
        adc_ready = 1'b1; adc_value = 14'h2AAA; tick();
        adc_ready = 1'b0; adc_value = 14'd0;
        chk("lastcyc_early", rsp_valid, 1'b0);
        tick();
        chk("lastcyc_rsp", rsp_valid, 1'b1);
        chk("lastcyc_flag", rsp_timeout, 1'b0);
        chk("lastcyc_val", rsp_value, 14'h2AAA);
        chk("lastcyc_count", timeout_count, 8'd1);

        // Saturation of the timeout counter.
        for (int i = 0; i < 253; i++) begin
            req = 4'b0001; tick(); req = 4'b0000;
            wait_rsp("to_loop");
        end
        chk("to_count254", timeout_count, 8'd254);
        for (int i = 0; i < 46; i++) begin
            req = 4'b0001; tick(); req = 4'b0000;
            wait_rsp("to_loop");
        end
        chk("to_count_sat", timeout_count, 8'd255);
        wait_idle("to_idle");

        // Request in the same cycle as its own grant queues a second conversion.
        base = rsp_seen;
        req = 4'b0100; tick(); tick(); req = 4'b0000;
        chk("race_pend", pending, 4'b0100);
        chk("race_sel", adc_sel, 2'd2);
        conv(2'd2, 14'h0222, "race_a");
        conv(2'd2, 14'h0333, "race_b");
        for (int k = 0; k < 30; k++) tick();
        chk("race_count", rsp_seen - base, 32'd2);
        chk("race_pend0", pending, 4'b0000);

        // adc_ready in IDLE, START and GAP is ignored.
        base = rsp_seen;
        adc_ready = 1'b1; adc_value = 14'h3FFF; tick(); adc_ready = 1'b0;
        req = 4'b0010; tick(); req = 4'b0000;
        wait_adc_req("ign_req");
        adc_ready = 1'b1; adc_value = 14'h1234; tick();
        adc_ready = 1'b0; adc_value = 14'd0; tick();
        chk("ign_start", rsp_valid, 1'b0);
        tick();
        adc_ready = 1'b1; adc_value = 14'h0555; tick();
        adc_ready = 1'b0; adc_value = 14'd0; tick();
        chk("ign_rsp", rsp_valid, 1'b1);
        chk("ign_val", rsp_value, 14'h0555);
        adc_ready = 1'b1; adc_value = 14'h3FFF; tick();
        adc_ready = 1'b0; adc_value = 14'd0;
        for (int k = 0; k < 30; k++) tick();
        chk("ign_count", rsp_seen - base, 32'd1);
        chk("ign_hold", rsp_value, 14'h0555);
        chk("ign_idle", busy, 1'b0);

        // Repeated pulses while pending merge.
        enable = 1'b0;
        req = 4'b0001; tick(); req = 4'b0000; tick();
        req = 4'b0001; tick(); req = 4'b0000; tick();
        req = 4'b0001; tick(); req = 4'b0000; tick();
        chk("merge_pend", pending, 4'b0001);
        chk("merge_busy", busy, 1'b0);
        base = rsp_seen;
        enable = 1'b1;
        conv(2'd0, 14'h0123, "merge");
        for (int k = 0; k < 30; k++) tick();
        chk("merge_count", rsp_seen - base, 32'd1);
        chk("merge_pend0", pending, 4'b0000);

        // Disable during SETTLE: the conversion finishes, no new grant.
        req = 4'b1000; tick(); req = 4'b0000; tick();
        enable = 1'b0; req = 4'b0010; tick(); req = 4'b0000;
        conv(2'd3, 14'h0ABC, "dis_conv");
        wait_idle("dis_idle");
        for (int k = 0; k < 8; k++) tick();
        chk("dis_busy", busy, 1'b0);
        chk("dis_pend", pending, 4'b0010);
        enable = 1'b1; tick();
        chk("reen_busy", busy, 1'b1);
        chk("reen_sel", adc_sel, 2'd1);
        chk("reen_pend", pending, 4'b0000);

        // Reset in WAIT abandons the conversion.
        wait_adc_req("rst_wait_req");
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rstw_pending", pending, 4'd0);
        chk("rstw_sel", adc_sel, 2'd0);
        chk("rstw_adcreq", adc_req, 1'b0);
        chk("rstw_rspv", rsp_valid, 1'b0);
        chk("rstw_id", rsp_id, 2'd0);
        chk("rstw_val", rsp_value, 14'd0);
        chk("rstw_to", rsp_timeout, 1'b0);
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_tcount", timeout_count, 8'd0);
        base = rsp_seen;
        for (int k = 0; k < 40; k++) tick();
        chk("rstw_norsp", rsp_seen - base, 32'd0);
        chk("rstw_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
